// File: rtl/vec_reg_port_arbiter.sv
// vec_reg_port_arbiter
//   Shares one vector register port between NUM_REQ burst requesters.
//   In IDLE a round-robin search picks the next requester and latches its
//   burst description. BURST then issues one element per unstalled cycle
//   until the whole burst is out, after which the block returns to IDLE.
//
// Handshake: a requester raises req_vld and holds it, together with its
// command, until it sees its done pulse. gnt marks every cycle in which one
// of its elements is issued. req_wdata must be valid whenever gnt is high.
// Read data comes back on rsp_vld/rsp_data one cycle after each read issue.
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   req_vld         per-requester burst request (held until done)
//   req_write       per-requester direction, 1 = write
//   req_reg         per-requester target vector register
//   req_len         per-requester burst length, 0 means 2^ADDR_W
//   req_wdata       per-requester write element
//   port_stall      register port busy, no issue this cycle
//   port_rdata      register file read data (one cycle after read issue)
//   gnt, done       per-requester issue strobe and last-element pulse
//   port_*          element command to the register port
//   rsp_vld         per-requester read response strobe
//   rsp_data        read response data
//   state_dbg       current FSM state (0 = IDLE, 1 = BURST)
module vec_reg_port_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int REG_SEL_W = 6,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_vld,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ-1:0][REG_SEL_W-1:0]   req_reg,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]      req_len,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_wdata,
    input  logic                                port_stall,
    input  logic [DATA_W-1:0]                   port_rdata,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic [NUM_REQ-1:0]                  done,
    output logic                                port_vld,
    output logic                                port_write,
    output logic [REG_SEL_W-1:0]                port_reg,
    output logic [ADDR_W-1:0]                   port_addr,
    output logic [DATA_W-1:0]                   port_wdata,
    output logic [NUM_REQ-1:0]                  rsp_vld,
    output logic [DATA_W-1:0]                   rsp_data,
    output logic                                state_dbg
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       owner;
    logic                   wr_lat;
    logic [REG_SEL_W-1:0]   reg_lat;
    logic [ADDR_W:0]        len_lat;     // one extra bit so length 0 can mean 2^ADDR_W
    logic [ADDR_W-1:0]      elem_cnt;
    logic                   rsp_pend;
    logic [PTR_W-1:0]       rsp_owner;

    logic                   sel_found;
    logic [PTR_W-1:0]       sel_id;
    logic                   issue;
    logic                   last;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!sel_found && req_vld[idx]) begin
                sel_found = 1'b1;
                sel_id    = PTR_W'(idx);
            end
        end
    end

    assign issue = (state == BURST) && !port_stall;
    // Compare at ADDR_W+1 bits so the 2^ADDR_W-element burst ends at index 2^ADDR_W-1.
    assign last  = ({1'b0, elem_cnt} == (len_lat - LEN_ONE));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_found) state_nxt = BURST;
            BURST:   if (issue && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            wr_lat    <= 1'b0;
            reg_lat   <= '0;
            len_lat   <= '0;
            elem_cnt  <= '0;
            rsp_pend  <= 1'b0;
            rsp_owner <= '0;
        end else begin
            state     <= state_nxt;
            rsp_pend  <= issue && !wr_lat;
            rsp_owner <= owner;
            if (state == IDLE && sel_found) begin
                owner    <= sel_id;
                wr_lat   <= req_write[sel_id];
                reg_lat  <= req_reg[sel_id];
                len_lat  <= (req_len[sel_id] == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                    : {1'b0, req_len[sel_id]};
                elem_cnt <= '0;
            end
            if (issue) begin
                elem_cnt <= elem_cnt + ADDR_W'(1);
                if (last) begin
                    rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
                end
            end
        end
    end

    // Command fields are zeroed when nothing issues so reset shows an all-zero port.
    always_comb begin
        gnt        = '0;
        done       = '0;
        rsp_vld    = '0;
        port_vld   = issue;
        port_write = issue && wr_lat;
        port_reg   = issue ? reg_lat : '0;
        port_addr  = issue ? elem_cnt : '0;
        if (issue) begin
            gnt[owner] = 1'b1;
            if (last) done[owner] = 1'b1;
        end
        if (rsp_pend) rsp_vld[rsp_owner] = 1'b1;
        rsp_data   = rsp_pend ? port_rdata : '0;
    end

    assign port_wdata = req_wdata[owner];
    assign state_dbg  = (state == BURST);

endmodule

// File: tb/tb_vec_reg_port_arbiter.sv
// Testbench for vec_reg_port_arbiter.
// A transaction-level model expands each granted burst into a queue of
// expected element commands; every unstalled BURST cycle pops one entry.
module tb_vec_reg_port_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int REG_SEL_W = 6;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 64;
    localparam int QW        = 2 + 1 + REG_SEL_W + ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]                 req_vld   = '0;
    logic [NUM_REQ-1:0]                 req_write = '0;
    logic [NUM_REQ-1:0][REG_SEL_W-1:0]  req_reg   = '0;
    logic [NUM_REQ-1:0][ADDR_W-1:0]     req_len   = '0;
    logic [NUM_REQ-1:0][DATA_W-1:0]     req_wdata = '0;
    logic                               port_stall = 1'b0;
    logic [DATA_W-1:0]                  port_rdata = '0;
    logic [NUM_REQ-1:0]                 gnt, done, rsp_vld;
    logic                               port_vld, port_write, state_dbg;
    logic [REG_SEL_W-1:0]               port_reg;
    logic [ADDR_W-1:0]                  port_addr;
    logic [DATA_W-1:0]                  port_wdata, rsp_data;

    vec_reg_port_arbiter #(
        .NUM_REQ(NUM_REQ), .REG_SEL_W(REG_SEL_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req_vld(req_vld), .req_write(req_write), .req_reg(req_reg),
        .req_len(req_len), .req_wdata(req_wdata),
        .port_stall(port_stall), .port_rdata(port_rdata),
        .gnt(gnt), .done(done),
        .port_vld(port_vld), .port_write(port_write), .port_reg(port_reg),
        .port_addr(port_addr), .port_wdata(port_wdata),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    logic [QW-1:0]      exp_q[$];   // {owner, write, reg, addr} per expected issue
    bit                 m_busy = 1'b0;
    int                 m_ptr  = 0;
    int                 m_rsp  = -1;

    // stimulus knobs
    logic [NUM_REQ-1:0] pend = '0;
    int  fix_len = -1, fix_write = -1, fix_reg = -1;
    int  stall_pct = 0, keep_pct = 0, new_pct = 0;
    bit  force_stall = 1'b0;

    task automatic model_reset();
        exp_q.delete();
        m_busy = 1'b0;
        m_ptr  = 0;
        m_rsp  = -1;
    endtask

    // Called mid-cycle with inputs settled: check outputs, then advance the
    // model by the upcoming clock edge.
    task automatic model_cycle();
        logic [QW-1:0]        e;
        int                   own, total, pick;
        bit                   was_busy, issue, wr;
        logic [REG_SEL_W-1:0] rg;
        logic [ADDR_W-1:0]    ad;
        was_busy = m_busy;
        check("state", 64'(state_dbg), 64'(was_busy));

        if (m_rsp >= 0) begin
            check("rsp_vld", 64'(rsp_vld), 64'(1) << m_rsp);
            check("rsp_data", rsp_data, port_rdata);
        end else begin
            check("rsp_vld", 64'(rsp_vld), 64'(0));
        end
        m_rsp = -1;

        issue = was_busy && !port_stall;
        if (issue) begin
            e   = exp_q.pop_front();
            own = int'(e[QW-1 -: 2]);
            wr  = e[REG_SEL_W + ADDR_W];
            rg  = e[ADDR_W +: REG_SEL_W];
            ad  = e[ADDR_W-1:0];
            check("gnt", 64'(gnt), 64'(1) << own);
            check("port_vld", 64'(port_vld), 64'(1));
            check("port_write", 64'(port_write), 64'(wr));
            check("port_reg", 64'(port_reg), 64'(rg));
            check("port_addr", 64'(port_addr), 64'(ad));
            if (wr) check("port_wdata", port_wdata, req_wdata[own]);
            else    m_rsp = own;
            if (exp_q.size() == 0) begin
                check("done", 64'(done), 64'(1) << own);
                m_busy    = 1'b0;
                m_ptr     = (own + 1) % NUM_REQ;
                pend[own] = (int'($urandom_range(0, 99)) < keep_pct);
            end else begin
                check("done", 64'(done), 64'(0));
            end
        end else begin
            check("gnt", 64'(gnt), 64'(0));
            check("port_vld", 64'(port_vld), 64'(0));
            check("done", 64'(done), 64'(0));
        end

        if (!was_busy && req_vld != '0) begin
            pick = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (pick < 0 && req_vld[(m_ptr + k) % NUM_REQ]) pick = (m_ptr + k) % NUM_REQ;
            end
            total = (req_len[pick] == '0) ? (1 << ADDR_W) : int'(req_len[pick]);
            for (int a = 0; a < total; a++) begin
                exp_q.push_back({2'(pick), req_write[pick], req_reg[pick], ADDR_W'(a)});
            end
            m_busy = 1'b1;
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && int'($urandom_range(0, 99)) < new_pct) pend[i] = 1'b1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(negedge clk);
        req_vld    = pend;
        port_stall = force_stall || (int'($urandom_range(0, 99)) < stall_pct);
        port_rdata = {$urandom, $urandom};
        for (int i = 0; i < NUM_REQ; i++) begin
            req_write[i] = (fix_write >= 0) ? 1'(fix_write) : 1'($urandom_range(0, 1));
            req_reg[i]   = (fix_reg >= 0) ? REG_SEL_W'(fix_reg) : REG_SEL_W'($urandom_range(0, 63));
            if (fix_len >= 0)                      req_len[i] = ADDR_W'(fix_len);
            else if ($urandom_range(0, 39) == 0)   req_len[i] = '0;
            else                                   req_len[i] = ADDR_W'($urandom_range(1, 5));
            req_wdata[i] = {$urandom, $urandom};
        end
        #1;
        model_cycle();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_gnt"}, 64'(gnt), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_port_vld"}, 64'(port_vld), 64'(0));
        check({tag, "_port_write"}, 64'(port_write), 64'(0));
        check({tag, "_port_reg"}, 64'(port_reg), 64'(0));
        check({tag, "_port_addr"}, 64'(port_addr), 64'(0));
        check({tag, "_rsp_vld"}, 64'(rsp_vld), 64'(0));
        check({tag, "_rsp_data"}, rsp_data, 64'(0));
        check({tag, "_state"}, 64'(state_dbg), 64'(0));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset      = 1'b1;
        req_vld    = pend;
        port_stall = 1'b0;
        #1;
        check_zero_outputs(tag);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    logic [NUM_REQ-1:0] order_q[$];
    int                 issue_cnt;

    initial begin
        // reset state
        #2;
        check_zero_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // single read burst from requester 2
        fix_len = 3; fix_write = 0; fix_reg = 5;
        pend = 4'b0100;
        repeat (7) step();

        // all four requesters, length 1, held: round-robin order
        do_reset("rst_rr");
        fix_len = 1; keep_pct = 100; pend = 4'b1111;
        order_q.delete();
        for (int c = 0; c < 12; c++) begin
            step();
            if (gnt != '0) order_q.push_back(gnt);
        end
        check("rr_count", 64'(order_q.size()), 64'(6));
        check("rr_0", 64'(order_q[0]), 64'(4'b0001));
        check("rr_1", 64'(order_q[1]), 64'(4'b0010));
        check("rr_2", 64'(order_q[2]), 64'(4'b0100));
        check("rr_3", 64'(order_q[3]), 64'(4'b1000));
        check("rr_4", 64'(order_q[4]), 64'(4'b0001));

        // write burst with a stall in the second issue cycle
        keep_pct = 0; pend = '0;
        do_reset("rst_stall");
        fix_len = 4; fix_write = 1; fix_reg = 9;
        pend = 4'b0010;
        step();                 // grant
        step();                 // addr 0
        force_stall = 1'b1;
        step();                 // stalled
        force_stall = 1'b0;
        repeat (4) step();      // addr 1,2,3 then idle

        // length 0 means 64 elements
        do_reset("rst_len0");
        fix_len = 0; fix_write = 0; fix_reg = 33;
        pend = 4'b0001;
        issue_cnt = 0;
        for (int c = 0; c < 70; c++) begin
            step();
            if (gnt[0]) issue_cnt++;
        end
        check("len0_issues", 64'(issue_cnt), 64'(64));

        // reset mid-burst at element 2, then 1 and 3 pending
        pend = '0;
        do_reset("rst_pre");
        fix_len = 5; fix_write = 0; fix_reg = 1;
        pend = 4'b0001;
        repeat (3) step();      // grant, addr 0, addr 1
        pend = 4'b1010;
        do_reset("rst_mid");
        fix_len = 2;
        step();                 // grant decision
        step();                 // first issue
        check("post_rst_gnt", 64'(gnt), 64'(4'b0010));
        repeat (6) step();

        // randomized traffic
        pend = '0;
        do_reset("rst_rand");
        fix_len = -1; fix_write = -1; fix_reg = -1;
        stall_pct = 25; keep_pct = 50; new_pct = 20;
        repeat (800) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/vec_reg_port_arbiter.md
VEC_REG_PORT_ARBITER -- requirements
Module: vec_reg_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters (load/store unit plus execution lanes) sharing one vector register port.
REQ-002 Parameter REG_SEL_W, default 6: vector register select width (64 registers).
REQ-003 Parameter ADDR_W, default 6: element address width (register depth 64).
REQ-004 Parameter DATA_W, default 64: element data width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_vld  in  NUM_REQ  per-requester burst request, held until its done pulse.
REQ-008 req_write  in  NUM_REQ  1 = write burst, 0 = read burst.
REQ-009 req_reg  in  NUM_REQ x REG_SEL_W  target vector register per requester.
REQ-010 req_len  in  NUM_REQ x ADDR_W  burst length in elements; 0 encodes 2^ADDR_W.
REQ-011 req_wdata  in  NUM_REQ x DATA_W  write element; valid whenever that requester's gnt is high.
REQ-012 port_stall  in  1  register port busy; suppresses issue this cycle.
REQ-013 port_rdata  in  DATA_W  register file read data, one cycle after a read issue.
REQ-014 gnt  out  NUM_REQ  one-hot; high in every cycle an element of that requester is issued.
REQ-015 done  out  NUM_REQ  one-cycle pulse on the last element issue of a burst.
REQ-016 port_vld, port_write  out  1 each  element issue strobe and direction.
REQ-017 port_reg  out  REG_SEL_W; port_addr  out  ADDR_W; port_wdata  out  DATA_W  issued element command.
REQ-018 rsp_vld  out  NUM_REQ; rsp_data  out  DATA_W  read data routed to the owning requester.

Function
REQ-019 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-020 In IDLE with any req_vld high, the block SHALL select the first set req_vld at or after rr_ptr, searching upward modulo NUM_REQ, and latch owner id, req_write, req_reg, and length, clear elem_cnt, and enter BURST on the next edge.
REQ-021 IDLE SHALL issue nothing, so a grant decision adds exactly one cycle before the first issue.
REQ-022 In BURST with port_stall low, the block SHALL drive port_vld=1, port_addr=elem_cnt, the latched port_reg and port_write, and gnt[owner]=1, and SHALL increment elem_cnt.
REQ-023 In BURST with port_stall high, port_vld and gnt SHALL be 0 and elem_cnt SHALL hold.
REQ-024 port_wdata SHALL equal req_wdata[owner] combinationally; it is don't-care when port_write is 0.
REQ-025 The last issue SHALL occur when elem_cnt equals latched length minus 1, computed at ADDR_W+1 bits so a length of 0 gives 2^ADDR_W elements. In that cycle done[owner] SHALL be 1, rr_ptr SHALL become (owner+1) mod NUM_REQ, and the FSM SHALL return to IDLE.
REQ-026 Once granted, a burst SHALL run to completion; changes on req_vld, req_reg, req_len or req_write of the owner during BURST SHALL be ignored.
REQ-027 Each read issue SHALL produce rsp_vld[owner]=1 exactly one cycle later with rsp_data=port_rdata; this includes the cycle after the last issue.
REQ-028 A requester whose req_vld is still high in the IDLE cycle after its done SHALL be treated as a new request, with round-robin priority against the others.
REQ-029 At most one bit of gnt, done and rsp_vld SHALL be set in any cycle.

Reset
REQ-030 When reset is asserted, the block SHALL immediately force state=IDLE, rr_ptr=0, elem_cnt=0, and owner=0, and drive gnt, done, port_vld, port_write, port_reg, port_addr, rsp_vld and rsp_data to 0.
REQ-031 Reset during BURST SHALL abort the burst with no done pulse and no further rsp_vld; after release the first grant follows REQ-020 from rr_ptr=0.

Verification
REQ-032 Requester 2 only, read, reg 5, len 3, no stall -> gnt[2] in cycles 2-4, port_addr 0,1,2, done[2] in cycle 4, rsp_vld[2] in cycles 3-5.
REQ-033 All four requesters assert together, len 1, held -> grant order 0,1,2,3,0, with one issue every 2 cycles.
REQ-034 Requester 1 writes len 4 with port_stall high in the 2nd issue cycle -> port_addr 0,(none),1,2,3; port_wdata tracks req_wdata[1]; done[1] on addr 3.
REQ-035 req_len=0 -> 64 issues with port_addr 0..63, done on addr 63, and no counter wrap before done.
REQ-036 Reset asserted mid-burst at elem_cnt 2 -> outputs 0 in the same cycle; after release with requesters 1 and 3 pending, requester 1 is granted first.
